// File: rtl/cache_mem_arbiter_pkg.sv
// Shared definitions for the cache-to-memory arbiter and the caches that sit
// around it: line/address widths, FSM state encoding and a sizing helper.
package cache_mem_arbiter_pkg;

    localparam int ARB_ADDR_W = 28;   // line address, byte address bits [31:4]
    localparam int ARB_LINE_W = 128;  // one cache line

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SERVE_I = 2'd1;
    localparam logic [1:0] S_SERVE_D = 2'd2;
    localparam logic [1:0] S_RESP    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = S_IDLE,
        ST_SERVE_I = S_SERVE_I,
        ST_SERVE_D = S_SERVE_D,
        ST_RESP    = S_RESP
    } arb_state_t;

    // Bits needed to hold a streak count of 0..limit.
    function automatic int streak_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_arb_priority_pick.sv
// Combinational winner selection: D-cache wins unless the I-cache has been
// passed over STARVE_LIMIT times in a row while waiting.
module arb_priority_pick #(
    parameter int STARVE_LIMIT = 2,
    parameter int STREAK_W     = 2
) (
    input  logic                i_req,
    input  logic                d_req_read,
    input  logic                d_req_write,
    input  logic [STREAK_W-1:0] streak,
    output logic                grant_i,
    output logic                grant_d,
    output logic                d_is_write
);

    localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(STARVE_LIMIT);

    logic d_any;

    // Priority decision; a write-back outranks a refill on the D side.
    always_comb begin
        d_any      = d_req_read | d_req_write;
        grant_d    = d_any & (~i_req | (streak < LIMIT));
        grant_i    = i_req & ~grant_d;
        d_is_write = d_req_write;
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares the single main-memory port between the I-cache refill path and the
// D-cache refill/write-back path. One transaction at a time; every
// memory-side output and every cache-side response comes from a register.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = ARB_ADDR_W,
    parameter int LINE_W       = ARB_LINE_W,
    parameter int STARVE_LIMIT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_req_read,
    input  logic              d_req_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy
);

    localparam int                  STREAK_W     = streak_width(STARVE_LIMIT);
    localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(STARVE_LIMIT);

    arb_state_t          state_reg, state_next;
    logic [STREAK_W-1:0] streak_reg;
    logic                mem_read_reg, mem_write_reg;
    logic [ADDR_W-1:0]   mem_addr_reg;
    logic [LINE_W-1:0]   mem_wdata_reg;
    logic [LINE_W-1:0]   i_rdata_reg, d_rdata_reg;
    logic                i_ready_reg, d_ready_reg;
    logic                grant_i, grant_d, d_is_write;

    arb_priority_pick #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .STREAK_W     (STREAK_W)
    ) u_pick (
        .i_req       (i_req),
        .d_req_read  (d_req_read),
        .d_req_write (d_req_write),
        .streak      (streak_reg),
        .grant_i     (grant_i),
        .grant_d     (grant_d),
        .d_is_write  (d_is_write)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: grant from IDLE, wait for memory, one response cycle, back.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (grant_d) begin
                    state_next = ST_SERVE_D;
                end else if (grant_i) begin
                    state_next = ST_SERVE_I;
                end
            end
            ST_SERVE_I, ST_SERVE_D: begin
                if (mem_ready) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Memory command, streak counter, line capture and the ready pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            streak_reg    <= '0;
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            i_rdata_reg   <= '0;
            d_rdata_reg   <= '0;
            i_ready_reg   <= 1'b0;
            d_ready_reg   <= 1'b0;
        end else begin
            i_ready_reg <= 1'b0;
            d_ready_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (grant_d) begin
                        mem_addr_reg  <= d_addr;
                        mem_wdata_reg <= d_wdata;
                        mem_write_reg <= d_is_write;
                        mem_read_reg  <= ~d_is_write;
                        // Only a D win that leaves the I-cache waiting extends the streak.
                        if (i_req) begin
                            streak_reg <= (streak_reg >= STREAK_LIMIT) ? STREAK_LIMIT
                                                                       : streak_reg + 1'b1;
                        end else begin
                            streak_reg <= '0;
                        end
                    end else if (grant_i) begin
                        mem_addr_reg  <= i_addr;
                        mem_read_reg  <= 1'b1;
                        mem_write_reg <= 1'b0;
                        streak_reg    <= '0;
                    end
                end
                ST_SERVE_I: begin
                    if (mem_ready) begin
                        mem_read_reg <= 1'b0;
                        i_rdata_reg  <= mem_rdata;
                        i_ready_reg  <= 1'b1;
                    end
                end
                ST_SERVE_D: begin
                    if (mem_ready) begin
                        mem_read_reg  <= 1'b0;
                        mem_write_reg <= 1'b0;
                        // A write-back returns no line; keep the last refill.
                        if (mem_read_reg) begin
                            d_rdata_reg <= mem_rdata;
                        end
                        d_ready_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_read  = mem_read_reg;
    assign mem_write = mem_write_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign i_rdata   = i_rdata_reg;
    assign d_rdata   = d_rdata_reg;
    assign i_ready   = i_ready_reg;
    assign d_ready   = d_ready_reg;
    assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: two cache requesters and a memory responder
// driven from queues; a transaction-level model predicts the grant order and
// returned lines, and a separate monitor checks each transaction as it runs.
module tb_cache_mem_arbiter;

    localparam int ADDR_W       = 28;
    localparam int LINE_W       = 128;
    localparam int STARVE_LIMIT = 2;

    typedef struct {
        bit               rd;
        bit               wr;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
    } dop_t;

    typedef struct {
        bit               is_i;
        bit               is_wr;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
        logic [LINE_W-1:0] exp_i;
        logic [LINE_W-1:0] exp_d;
    } txn_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_req = 1'b0;
    logic [ADDR_W-1:0] i_addr = '0;
    logic [LINE_W-1:0] i_rdata;
    logic              i_ready;
    logic              d_req_read = 1'b0;
    logic              d_req_write = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [LINE_W-1:0] d_wdata = '0;
    logic [LINE_W-1:0] d_rdata;
    logic              d_ready;
    logic              mem_read, mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata = '0;
    logic              mem_ready = 1'b0;
    logic              busy;

    cache_mem_arbiter #(
        .ADDR_W       (ADDR_W),
        .LINE_W       (LINE_W),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req       (i_req),
        .i_addr      (i_addr),
        .i_rdata     (i_rdata),
        .i_ready     (i_ready),
        .d_req_read  (d_req_read),
        .d_req_write (d_req_write),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_ready     (d_ready),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Requester queues, model state, scoreboard.
    logic [ADDR_W-1:0] iq[$];
    dop_t              dq[$];
    logic [ADDR_W-1:0] bi[$];
    dop_t              bd[$];
    txn_t              exp_q[$];
    logic [LINE_W-1:0] model_mem[logic [ADDR_W-1:0]];
    logic [LINE_W-1:0] resp_mem[logic [ADDR_W-1:0]];
    int                m_streak = 0;
    logic [LINE_W-1:0] m_i_rdata = '0;
    logic [LINE_W-1:0] m_d_rdata = '0;

    bit req_en     = 1'b1;
    bit resp_en    = 1'b1;
    bit mon_en     = 1'b1;
    bit stray_req  = 1'b0;
    bit stray_done = 1'b0;
    int fix_delay  = -1;
    int mr_cyc     = -100;

    task automatic chk(input bit ok, input string name,
                       input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic logic [LINE_W-1:0] line_init(input logic [ADDR_W-1:0] a);
        logic [LINE_W-1:0] base;
        base = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
        return base ^ {100'd0, a};
    endfunction

    function automatic logic [LINE_W-1:0] model_get(input logic [ADDR_W-1:0] a);
        return model_mem.exists(a) ? model_mem[a] : line_init(a);
    endfunction

    function automatic logic [LINE_W-1:0] resp_get(input logic [ADDR_W-1:0] a);
        return resp_mem.exists(a) ? resp_mem[a] : line_init(a);
    endfunction

    // Predict the whole batch from the arbitration rules, then hand it to the requesters.
    task automatic load_batch();
        logic [ADDR_W-1:0] wi[$];
        dop_t              wd[$];
        dop_t              h;
        txn_t              t;
        bit                ip, dp, take_d;
        wi = bi;
        wd = bd;
        while (wi.size() > 0 || wd.size() > 0) begin
            ip     = (wi.size() > 0);
            dp     = (wd.size() > 0);
            take_d = dp && (!ip || m_streak < STARVE_LIMIT);
            t.wdata = '0;
            if (take_d) begin
                m_streak = ip ? ((m_streak + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_streak + 1) : 0;
                h = wd[0];
                t.is_i = 1'b0;
                t.addr = h.addr;
                if (h.wr) begin
                    t.is_wr = 1'b1;
                    t.wdata = h.wdata;
                    model_mem[h.addr] = h.wdata;
                    if (h.rd) begin
                        h.wr  = 1'b0;
                        wd[0] = h;
                    end else begin
                        void'(wd.pop_front());
                    end
                end else begin
                    t.is_wr   = 1'b0;
                    m_d_rdata = model_get(h.addr);
                    void'(wd.pop_front());
                end
            end else begin
                m_streak  = 0;
                t.is_i    = 1'b1;
                t.is_wr   = 1'b0;
                t.addr    = wi[0];
                m_i_rdata = model_get(wi[0]);
                void'(wi.pop_front());
            end
            t.exp_i = m_i_rdata;
            t.exp_d = m_d_rdata;
            exp_q.push_back(t);
        end
        foreach (bi[k]) iq.push_back(bi[k]);
        foreach (bd[k]) dq.push_back(bd[k]);
        bi.delete();
        bd.delete();
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() > 0 || iq.size() > 0 || dq.size() > 0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            chk(1'b0, "drain_timeout", 128'(exp_q.size()), 128'(0));
            exp_q.delete();
            iq.delete();
            dq.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    function automatic dop_t mk_dop(input bit rd, input bit wr,
                                    input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] w);
        dop_t o;
        o.rd = rd; o.wr = wr; o.addr = a; o.wdata = w;
        return o;
    endfunction

    function automatic logic [LINE_W-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Cache requesters: hold the queue head as a level, retire it when ready is seen.
    initial forever begin
        dop_t h;
        @(negedge clk);
        if (i_ready && iq.size() > 0) void'(iq.pop_front());
        if (d_ready && dq.size() > 0) begin
            h = dq[0];
            if (h.wr && h.rd) begin
                h.wr  = 1'b0;
                dq[0] = h;
            end else begin
                void'(dq.pop_front());
            end
        end
        i_req = req_en && (iq.size() > 0);
        if (iq.size() > 0) i_addr = iq[0];
        if (req_en && dq.size() > 0) begin
            h           = dq[0];
            d_req_read  = h.rd;
            d_req_write = h.wr;
            d_addr      = h.addr;
            d_wdata     = h.wdata;
        end else begin
            d_req_read  = 1'b0;
            d_req_write = 1'b0;
        end
    end

    // Memory responder: random (or fixed) latency, single-cycle mem_ready pulse.
    initial begin
        bit in_txn;
        int cnt;
        in_txn = 1'b0;
        cnt    = 0;
        forever begin
            @(negedge clk);
            mem_rdata = rand_line();
            if (mem_ready) begin
                mem_ready = 1'b0;
                in_txn    = 1'b0;
            end else if (resp_en && (mem_read || mem_write)) begin
                if (!in_txn) begin
                    in_txn = 1'b1;
                    cnt    = (fix_delay >= 0) ? fix_delay : int'($urandom_range(0, 3));
                end
                if (cnt == 0) begin
                    mem_ready = 1'b1;
                    mr_cyc    = cyc;
                    if (mem_write) resp_mem[mem_addr] = mem_wdata;
                    else mem_rdata = resp_get(mem_addr);
                end else begin
                    cnt--;
                end
            end else if (stray_req && !stray_done) begin
                mem_ready  = 1'b1;
                stray_done = 1'b1;
            end
        end
    end

    // Monitor: check each grant against the scoreboard head and each response as it pops.
    initial begin
        txn_t t;
        bit   prev_strobe, post;
        prev_strobe = 1'b0;
        post        = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (post) begin
                    chk(!busy && !i_ready && !d_ready, "idle_after_resp",
                        128'({busy, i_ready, d_ready}), 128'(0));
                    post = 1'b0;
                end
                if ((mem_read || mem_write) && !prev_strobe) begin
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "unexpected_grant", 128'(mem_addr), 128'(0));
                    end else begin
                        t = exp_q[0];
                        chk(mem_write == t.is_wr && mem_read == !t.is_wr, "grant_cmd",
                            128'({mem_read, mem_write}), 128'({!t.is_wr, t.is_wr}));
                        chk(mem_addr == t.addr, "grant_addr", 128'(mem_addr), 128'(t.addr));
                        if (t.is_wr) chk(mem_wdata == t.wdata, "grant_wdata", mem_wdata, t.wdata);
                    end
                end
                if (i_ready || d_ready) begin
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "unexpected_ready", 128'({i_ready, d_ready}), 128'(0));
                    end else begin
                        t = exp_q.pop_front();
                        chk(i_ready == t.is_i && d_ready == !t.is_i, "ready_side",
                            128'({i_ready, d_ready}), 128'({t.is_i, !t.is_i}));
                        chk(cyc == mr_cyc + 1, "ready_latency", 128'(cyc), 128'(mr_cyc + 1));
                        chk(mem_addr == t.addr, "addr_held", 128'(mem_addr), 128'(t.addr));
                        chk(i_rdata == t.exp_i, "i_rdata", i_rdata, t.exp_i);
                        chk(d_rdata == t.exp_d, "d_rdata", d_rdata, t.exp_d);
                    end
                    post = 1'b1;
                end
            end
            prev_strobe = mem_read || mem_write;
        end
    end

    // Stimulus sequence.
    initial begin
        int n;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk(!i_ready && !d_ready && !mem_read && !mem_write && !busy, "reset_ctrl",
            128'({i_ready, d_ready, mem_read, mem_write, busy}), 128'(0));
        chk(i_rdata == '0 && d_rdata == '0, "reset_rdata", i_rdata | d_rdata, 128'(0));
        chk(mem_addr == '0 && mem_wdata == '0, "reset_mem_bus", mem_wdata | 128'(mem_addr), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Lone I-cache miss, memory answers after three wait cycles.
        fix_delay = 3;
        bi.push_back(28'h0000010);
        load_batch();
        wait_drain();
        fix_delay = -1;

        // Write-back then refill of the same line.
        bd.push_back(mk_dop(1'b0, 1'b1, 28'h20, {4{32'hAAAA_AAAA}}));
        bd.push_back(mk_dop(1'b1, 1'b0, 28'h20, '0));
        load_batch();
        wait_drain();

        // Simultaneous I and D refills.
        bi.push_back(28'h11);
        bd.push_back(mk_dop(1'b1, 1'b0, 28'h21, '0));
        load_batch();
        wait_drain();

        // I held while D requests keep coming: starvation guard kicks in.
        bi.push_back(28'h12);
        bi.push_back(28'h13);
        for (int k = 0; k < 4; k++) bd.push_back(mk_dop(1'b1, 1'b0, 28'(32'h24 + k), '0));
        load_batch();
        wait_drain();

        // Read and write raised together: write first, read afterwards.
        bd.push_back(mk_dop(1'b1, 1'b1, 28'h22, rand_line()));
        load_batch();
        wait_drain();

        // Random batches.
        for (int b = 0; b < 25; b++) begin
            int ni, nd, r;
            ni = $urandom_range(0, 3);
            nd = $urandom_range(0, 4);
            if (ni == 0 && nd == 0) ni = 1;
            for (int k = 0; k < ni; k++) bi.push_back(28'(32'h10 + $urandom_range(0, 23)));
            for (int k = 0; k < nd; k++) begin
                r = $urandom_range(0, 9);
                bd.push_back(mk_dop(r < 4 || r >= 8, r >= 4, 28'(32'h20 + $urandom_range(0, 7)),
                                    rand_line()));
            end
            load_batch();
            wait_drain();
        end

        // Reset while a D refill is outstanding; memory never answers it.
        mon_en  = 1'b0;
        resp_en = 1'b0;
        dq.push_back(mk_dop(1'b1, 1'b0, 28'h23, '0));
        n = 0;
        while (!mem_read && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(mem_read == 1'b1, "rst_test_grant", 128'(mem_read), 128'(1));
        rst_n  = 1'b0;
        req_en = 1'b0;
        dq.delete();
        iq.delete();
        @(negedge clk);
        chk(!i_ready && !d_ready && !mem_read && !mem_write && !busy, "midrst_ctrl",
            128'({i_ready, d_ready, mem_read, mem_write, busy}), 128'(0));
        chk(i_rdata == '0 && d_rdata == '0, "midrst_rdata", i_rdata | d_rdata, 128'(0));
        chk(mem_addr == '0 && mem_wdata == '0, "midrst_mem_bus", mem_wdata | 128'(mem_addr), 128'(0));
        rst_n     = 1'b1;
        stray_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk(!i_ready && !d_ready && !mem_read && !mem_write && !busy, "stray_ignored",
                128'({i_ready, d_ready, mem_read, mem_write, busy}), 128'(0));
        end
        chk(stray_done == 1'b1, "stray_issued", 128'(stray_done), 128'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
